// File: rtl/lbus_arbiter_pkg.sv
// Shared constants and state encoding for the PL local-bus arbiter.
package lbus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ID_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT,
    DONE
  } lbus_state_e;

endpackage

// File: rtl/lbus_arbiter_if.sv
// Requester handshake plus local-bus signals of the arbiter.
// master: the arbiter side; slave: requesters and bus target side.
interface lbus_arbiter_if
  import lbus_pkg::*;
#(
  parameter int unsigned NREQ = 2
) ();

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_wr;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wrdata;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      rddata;
  logic                   busy;
  logic [ID_W-1:0]        gnt_id;
  logic [ADDR_W-1:0]      baddr;
  logic [DATA_W-1:0]      bwrdata;
  logic                   bwr;
  logic                   bstrobe;
  logic [DATA_W-1:0]      brddata;

  modport master (
    input  req, req_wr, req_addr, req_wrdata, brddata,
    output ack, rddata, busy, gnt_id, baddr, bwrdata, bwr, bstrobe
  );

  modport slave (
    output req, req_wr, req_addr, req_wrdata, brddata,
    input  ack, rddata, busy, gnt_id, baddr, bwrdata, bwr, bstrobe
  );

endinterface

// File: rtl/lbus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward
// from last+1, wrapping modulo NREQ.
module rr_pick
  import lbus_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last,
  output logic            valid,
  output logic [ID_W-1:0] idx
);

  // Walk candidates from farthest to nearest so the nearest one wins.
  always_comb begin
    int unsigned cand;
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      cand = (32'(last) + k) % NREQ;
      if ((req & (NREQ'(1) << cand)) != '0) begin
        valid = 1'b1;
        idx   = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/lbus_arbiter.sv
// Round-robin arbiter sharing the 16-bit PL local bus between NREQ
// requesters; one transaction at a time, all outputs registered.
module lbus_arbiter
  import lbus_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  lbus_arbiter_if.master bus
);

  lbus_state_e       state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d;
  logic [DATA_W-1:0] bwrdata_q, bwrdata_d;
  logic              bwr_q, bwr_d;
  logic [DATA_W-1:0] rddata_q, rddata_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              bstrobe_q, bstrobe_d;
  logic              busy_q, busy_d;

  logic              pick_valid;
  logic [ID_W-1:0]   pick_idx;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (bus.req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    baddr_d   = baddr_q;
    bwrdata_d = bwrdata_q;
    bwr_d     = bwr_q;
    rddata_d  = rddata_q;
    ack_d     = '0;
    bstrobe_d = 1'b0;
    busy_d    = busy_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d     = pick_idx;
          last_d    = pick_idx;
          // Winner fields selected by shifting the packed vectors down.
          baddr_d   = ADDR_W'(bus.req_addr >> (32'(pick_idx) * ADDR_W));
          bwrdata_d = DATA_W'(bus.req_wrdata >> (32'(pick_idx) * DATA_W));
          bwr_d     = |(bus.req_wr & (NREQ'(1) << pick_idx));
          bstrobe_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = STROBE;
        end
      end
      STROBE: begin
        if (bwr_q) begin
          ack_d   = NREQ'(1) << gnt_q;
          state_d = DONE;
        end else begin
          cnt_d   = 4'(RD_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rddata_d = bus.brddata;
          ack_d    = NREQ'(1) << gnt_q;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= ID_W'(NREQ - 1);
      gnt_q     <= '0;
      cnt_q     <= '0;
      baddr_q   <= '0;
      bwrdata_q <= '0;
      bwr_q     <= 1'b0;
      rddata_q  <= '0;
      ack_q     <= '0;
      bstrobe_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      baddr_q   <= baddr_d;
      bwrdata_q <= bwrdata_d;
      bwr_q     <= bwr_d;
      rddata_q  <= rddata_d;
      ack_q     <= ack_d;
      bstrobe_q <= bstrobe_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.rddata  = rddata_q;
  assign bus.busy    = busy_q;
  assign bus.gnt_id  = gnt_q;
  assign bus.baddr   = baddr_q;
  assign bus.bwrdata = bwrdata_q;
  assign bus.bwr     = bwr_q;
  assign bus.bstrobe = bstrobe_q;

endmodule

// File: tb/tb_lbus_arbiter.sv
// Bench for lbus_arbiter: directed transactions with literal expectations
// plus a timeline model checked every cycle.
module tb_lbus_arbiter;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned RD_LAT = 3;
  localparam int unsigned AW     = NREQ * 16;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  lbus_arbiter_if #(.NREQ(NREQ)) bus ();

  lbus_arbiter #(.NREQ(NREQ), .RD_LATENCY(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- requester agents and bus target ----------------
  int   ack_cnt [NREQ];
  int   rearm   [NREQ];
  bit   hold    [NREQ];
  bit   auto_rq [NREQ];
  int   rd_due = -100;
  logic [15:0] rd_addr = '0;
  logic prev_strobe = 1'b0;
  int   adj_strobes = 0;
  bit   rec_gnt = 1'b0;
  int   gnt_seq[$];

  task automatic set_req(int i, logic wr, logic [15:0] a, logic [15:0] d);
    bus.req = bus.req | (NREQ'(1) << i);
    if (wr) bus.req_wr = bus.req_wr | (NREQ'(1) << i);
    else    bus.req_wr = bus.req_wr & ~(NREQ'(1) << i);
    bus.req_addr   = (bus.req_addr & ~(AW'(16'hFFFF) << (16 * i))) | (AW'(a) << (16 * i));
    bus.req_wrdata = (bus.req_wrdata & ~(AW'(16'hFFFF) << (16 * i))) | (AW'(d) << (16 * i));
  endtask

  // Advance to just after the next rising edge and run the agents.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.bstrobe && prev_strobe) adj_strobes++;
    prev_strobe = bus.bstrobe;
    if (bus.bstrobe) begin
      if (rec_gnt) gnt_seq.push_back(int'(bus.gnt_id));
      if (!bus.bwr) begin
        rd_due  = cyc + RD_LAT;
        rd_addr = bus.baddr;
      end
    end
    bus.brddata = (cyc == rd_due) ? (rd_addr ^ 16'hFFFF) : 16'hDEAD;
    for (int i = 0; i < NREQ; i++) begin
      if (((bus.ack >> i) & NREQ'(1)) != '0) begin
        ack_cnt[i]++;
        if (!hold[i]) begin
          bus.req = bus.req & ~(NREQ'(1) << i);
          if (auto_rq[i]) rearm[i] = 2;
        end
      end else if (rearm[i] > 0) begin
        rearm[i]--;
        if (rearm[i] == 0 && auto_rq[i])
          set_req(i, (i != 2), 16'(16'h0100 * (i + 1) + ack_cnt[i]), 16'($urandom));
      end
    end
  endtask

  task automatic wait_idle(string name, int limit);
    int n;
    n = 0;
    while (!(bus.req == '0 && !bus.busy) && n < limit) begin
      tick();
      n++;
    end
    check(name, 16'(bus.req == '0 && !bus.busy), 16'd1);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_ack"},     16'(bus.ack),     16'h0000);
    check({tag, "_busy"},    16'(bus.busy),    16'h0000);
    check({tag, "_bstrobe"}, 16'(bus.bstrobe), 16'h0000);
    check({tag, "_gnt"},     16'(bus.gnt_id),  16'h0000);
    check({tag, "_baddr"},   bus.baddr,        16'h0000);
    check({tag, "_bwrdata"}, bus.bwrdata,      16'h0000);
    check({tag, "_bwr"},     16'(bus.bwr),     16'h0000);
    check({tag, "_rddata"},  bus.rddata,       16'h0000);
  endtask

  // ---------------- timeline model, checked each cycle ----------------
  // A transaction sampled in cycle t0 occupies cycles t0+1 .. t0+len,
  // strobing at t0+1 and acking at t0+len (len = 2 write, 2+RD_LAT read).
  function automatic int pick_rr(logic [NREQ-1:0] r, int lst);
    int j;
    for (int k = 1; k <= NREQ; k++) begin
      j = (lst + k) % NREQ;
      if (((r >> j) & NREQ'(1)) != '0) return j;
    end
    return -1;
  endfunction

  initial begin : model
    bit   model_ok, pend_reset, pend_new, pend_rd, active;
    int   m_t0, m_len, m_win, m_last, p_win;
    logic [15:0] m_baddr, m_bwrdata, m_rddata, p_addr, p_data, p_rd;
    logic m_bwr, p_wr;
    logic [NREQ-1:0] exp_ack;
    model_ok = 0; pend_reset = 0; pend_new = 0; pend_rd = 0;
    m_t0 = -1; m_len = 0; m_win = 0; m_last = NREQ - 1; p_win = 0;
    m_baddr = '0; m_bwrdata = '0; m_rddata = '0; m_bwr = 1'b0;
    p_addr = '0; p_data = '0; p_rd = '0; p_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (pend_reset) begin
        model_ok = 1; pend_reset = 0; pend_new = 0; pend_rd = 0;
        m_t0 = -1; m_len = 0; m_win = 0; m_last = NREQ - 1;
        m_baddr = '0; m_bwrdata = '0; m_rddata = '0; m_bwr = 1'b0;
      end else begin
        if (pend_new) begin
          m_t0 = cyc - 1; m_win = p_win; m_baddr = p_addr;
          m_bwrdata = p_data; m_bwr = p_wr; m_len = p_wr ? 2 : 2 + RD_LAT;
          pend_new = 0;
        end
        if (pend_rd) begin
          m_rddata = p_rd;
          pend_rd = 0;
        end
      end
      if (model_ok) begin
        active  = (m_t0 >= 0) && (cyc >= m_t0 + 1) && (cyc <= m_t0 + m_len);
        exp_ack = (active && cyc == m_t0 + m_len) ? (NREQ'(1) << m_win) : '0;
        check("m_busy",    16'(bus.busy),    16'(active));
        check("m_bstrobe", 16'(bus.bstrobe), 16'(active && cyc == m_t0 + 1));
        check("m_ack",     16'(bus.ack),     16'(exp_ack));
        check("m_gnt",     16'(bus.gnt_id),  16'(m_win));
        check("m_baddr",   bus.baddr,        m_baddr);
        check("m_rddata",  bus.rddata,       m_rddata);
        if (active && cyc == m_t0 + 1) begin
          check("m_bwr", 16'(bus.bwr), 16'(m_bwr));
          if (m_bwr) check("m_bwrdata", bus.bwrdata, m_bwrdata);
        end
      end
      if (reset) begin
        pend_reset = 1;
      end else if (model_ok) begin
        if (m_t0 < 0 || cyc > m_t0 + m_len) begin
          if (bus.req != '0) begin
            p_win    = pick_rr(bus.req, m_last);
            m_last   = p_win;
            p_addr   = 16'(bus.req_addr >> (16 * p_win));
            p_data   = 16'(bus.req_wrdata >> (16 * p_win));
            p_wr     = ((bus.req_wr >> p_win) & NREQ'(1)) != '0;
            pend_new = 1;
          end
        end else if (!m_bwr && cyc == m_t0 + 1 + RD_LAT) begin
          p_rd    = bus.brddata;
          pend_rd = 1;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int n, mx, mn;
    reset = 1'b1;
    bus.req = '0; bus.req_wr = '0; bus.req_addr = '0; bus.req_wrdata = '0;
    bus.brddata = 16'hDEAD;
    for (int i = 0; i < NREQ; i++) begin
      ack_cnt[i] = 0; rearm[i] = 0; hold[i] = 0; auto_rq[i] = 0;
    end
    tick(); tick();
    reset = 1'b0;
    check_reset_outputs("reset");

    // Single write by requester 0; address change after sampling is ignored.
    set_req(0, 1'b1, 16'h0012, 16'hBEEF);
    tick();
    set_req(0, 1'b1, 16'h0FFF, 16'h1111);
    check("wr_strobe",  16'(bus.bstrobe), 16'd1);
    check("wr_baddr",   bus.baddr,        16'h0012);
    check("wr_bwrdata", bus.bwrdata,      16'hBEEF);
    check("wr_bwr",     16'(bus.bwr),     16'd1);
    check("wr_busy1",   16'(bus.busy),    16'd1);
    tick();
    check("wr_ack",     16'(bus.ack),     16'b001);
    check("wr_busy2",   16'(bus.busy),    16'd1);
    check("wr_hold",    bus.baddr,        16'h0012);
    tick();
    check("wr_busy3",   16'(bus.busy),    16'd0);

    // Single read by requester 1; target returns addr ^ FFFF.
    set_req(1, 1'b0, 16'hA5A5, 16'h0000);
    tick();
    check("rd_strobe", 16'(bus.bstrobe), 16'd1);
    check("rd_bwr",    16'(bus.bwr),     16'd0);
    check("rd_gnt",    16'(bus.gnt_id),  16'd1);
    repeat (4) tick();
    check("rd_ack",    16'(bus.ack),     16'b010);
    check("rd_data",   bus.rddata,       16'h5A5A);
    tick();

    // Contention straight after reset: requester 0 first.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, 16'h0001, 16'hAAAA);
    set_req(1, 1'b1, 16'h0002, 16'hBBBB);
    tick();
    check("ct_baddr0", bus.baddr,        16'h0001);
    check("ct_gnt0",   16'(bus.gnt_id),  16'd0);
    tick();
    check("ct_ack0",   16'(bus.ack),     16'b001);
    tick(); tick();
    check("ct_strobe1", 16'(bus.bstrobe), 16'd1);
    check("ct_baddr1",  bus.baddr,        16'h0002);
    check("ct_gnt1",    16'(bus.gnt_id),  16'd1);
    tick();
    check("ct_ack1",   16'(bus.ack),     16'b010);
    tick();

    // Sustained load: all requesters re-request two cycles after each ack.
    for (int i = 0; i < NREQ; i++) begin
      ack_cnt[i] = 0;
      auto_rq[i] = 1;
      set_req(i, (i != 2), 16'(16'h0100 * (i + 1)), 16'($urandom));
    end
    rec_gnt = 1'b1;
    n = 0;
    while ((ack_cnt[0] + ack_cnt[1] + ack_cnt[2]) < 30 && n < 1000) begin
      tick();
      n++;
    end
    check("ld_count", 16'((ack_cnt[0] + ack_cnt[1] + ack_cnt[2]) >= 30), 16'd1);
    for (int i = 0; i < NREQ; i++) auto_rq[i] = 0;
    wait_idle("ld_drain", 200);
    rec_gnt = 1'b0;
    for (int k = 1; k < gnt_seq.size(); k++)
      check("ld_rotation", 16'(gnt_seq[k]), 16'((gnt_seq[k-1] + 1) % NREQ));
    mx = ack_cnt[0]; mn = ack_cnt[0];
    for (int i = 1; i < NREQ; i++) begin
      if (ack_cnt[i] > mx) mx = ack_cnt[i];
      if (ack_cnt[i] < mn) mn = ack_cnt[i];
    end
    check("ld_fair", 16'((mx - mn) <= 1), 16'd1);

    // Reset during the WAIT of a read: no ack, pointer back to NREQ-1.
    set_req(0, 1'b0, 16'h1234, 16'h0000);
    tick();
    check("rs_strobe", 16'(bus.bstrobe), 16'd1);
    check("rs_gnt",    16'(bus.gnt_id),  16'd0);
    tick();
    reset = 1'b1;
    check("rs_noack",  16'(bus.ack),     16'd0);
    tick();
    reset = 1'b0;
    check_reset_outputs("rs");
    set_req(1, 1'b1, 16'h0222, 16'h3333);
    tick();
    check("rs_restrobe", 16'(bus.bstrobe), 16'd1);
    check("rs_regnt",    16'(bus.gnt_id),  16'd0);
    check("rs_readdr",   bus.baddr,        16'h1234);
    wait_idle("rs_drain", 100);

    // Request held through ack: a duplicate transaction is expected.
    hold[0] = 1;
    set_req(0, 1'b1, 16'h0077, 16'h1111);
    tick();
    check("dup_strobe1", 16'(bus.bstrobe), 16'd1);
    tick();
    check("dup_ack1",    16'(bus.ack),     16'b001);
    tick(); tick();
    check("dup_strobe2", 16'(bus.bstrobe), 16'd1);
    check("dup_baddr2",  bus.baddr,        16'h0077);
    $display("note: held request produced a duplicate transaction at cycle %0d (expected)", cyc);
    hold[0] = 0;
    wait_idle("dup_drain", 50);

    check("no_adjacent_strobes", 16'(adj_strobes), 16'd0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
